rsa_exp_sequencer: RTL and testbench

Sequencer for the RSA modular-exponentiation engine. It drives the shared Montgomery multiplier through the left-to-right square-and-multiply schedule, using the preloaded N, R mod N and R² mod N operands. It sits between the CSR command/exponent registers and the multiplier/operand register file. It issues operand selects, multiplier start pulses and result write-backs, and reports busy/done to the status register.

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/rsa_exp_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_rsa_exp_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation sequencer: state encoding,
// multiplier operand-select codes, write-back destination codes and default widths.
package rsa_pkg;

    localparam int unsigned EXP_W_DEF = 32;
    localparam int unsigned LEN_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_INIT_A = 3'd2,
        ST_SQ     = 3'd3,
        ST_MUL    = 3'd4,
        ST_POST   = 3'd5,
        ST_FIN    = 3'd6
    } seq_state_e;

    // Operand A select codes
    localparam logic [1:0] A_SEL_AREG = 2'd0;
    localparam logic [1:0] A_SEL_M    = 2'd1;

    // Operand B select codes
    localparam logic [1:0] B_SEL_AREG = 2'd0;
    localparam logic [1:0] B_SEL_XT   = 2'd1;
    localparam logic [1:0] B_SEL_R2N  = 2'd2;
    localparam logic [1:0] B_SEL_ONE  = 2'd3;

    // Write-back destination codes
    localparam logic DST_A  = 1'b0;
    localparam logic DST_XT = 1'b1;

endpackage

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery multiplier.
// Ports:
//   clk, resetn         clock, async active-low reset
//   start, exp, exp_len command level, exponent and exponent length (sampled on launch)
//   busy, done          run status
//   mm_start            one-cycle multiplier launch pulse
//   mm_a_sel, mm_b_sel  operand selects, held for the whole multiplication state
//   mm_done, mm_busy    multiplier completion pulse / activity
//   wr_en, wr_dst       result write-back strobe (combinational from mm_done) and target
//   load_a_rn           copy R mod N into the A register
//   mult_cnt            multiplications issued in the current or last run
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [EXP_W-1:0] exp,
    input  logic [LEN_W-1:0] exp_len,
    output logic             busy,
    output logic             done,
    output logic             mm_start,
    output logic [1:0]       mm_a_sel,
    output logic [1:0]       mm_b_sel,
    input  logic             mm_done,
    input  logic             mm_busy,
    output logic             wr_en,
    output logic             wr_dst,
    output logic             load_a_rn,
    output logic [15:0]      mult_cnt
);

    seq_state_e       state_q, state_d;
    logic             start_q, start_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] i_q, i_d;
    logic [15:0]      mult_cnt_q, mult_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mm_start_q, mm_start_d;
    logic [1:0]       a_sel_q, a_sel_d;
    logic [1:0]       b_sel_q, b_sel_d;
    logic             wr_dst_q, wr_dst_d;
    logic             load_a_rn_q, load_a_rn_d;

    logic             launch;
    logic             issue;
    logic             cur_bit;
    logic             in_mult;
    logic [LEN_W-1:0] len_clamped;

    // Launch needs a rising edge of start and an idle multiplier
    assign launch      = (state_q == ST_IDLE) && start && !start_q && !mm_busy;
    assign len_clamped = (exp_len > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : exp_len;
    assign cur_bit     = |(exp_q & (EXP_W'(1) << i_q));
    assign in_mult     = (state_q == ST_PRE) || (state_q == ST_SQ) ||
                         (state_q == ST_MUL) || (state_q == ST_POST);

    // Write-back follows the completion pulse; an aborting cycle never writes
    assign wr_en = mm_done && in_mult && start;

    // Next-state, schedule bookkeeping and registered output values
    always_comb begin
        state_d     = state_q;
        start_d     = start;
        exp_d       = exp_q;
        len_d       = len_q;
        i_d         = i_q;
        mult_cnt_d  = mult_cnt_q;
        issue       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mm_start_d  = 1'b0;
        a_sel_d     = A_SEL_AREG;
        b_sel_d     = B_SEL_AREG;
        wr_dst_d    = DST_A;
        load_a_rn_d = 1'b0;

        if ((state_q != ST_IDLE) && (state_q != ST_FIN) && !start) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        exp_d      = exp;
                        len_d      = len_clamped;
                        i_d        = len_clamped - LEN_W'(1);
                        mult_cnt_d = '0;
                        state_d    = ST_PRE;
                        issue      = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (mm_done) begin
                        state_d = ST_INIT_A;
                    end
                end
                ST_INIT_A: begin
                    issue   = 1'b1;
                    state_d = (len_q == '0) ? ST_POST : ST_SQ;
                end
                ST_SQ: begin
                    if (mm_done) begin
                        issue = 1'b1;
                        if (cur_bit) begin
                            state_d = ST_MUL;
                        end else if (i_q == '0) begin
                            state_d = ST_POST;
                        end else begin
                            i_d = i_q - LEN_W'(1);
                        end
                    end
                end
                ST_MUL: begin
                    if (mm_done) begin
                        issue = 1'b1;
                        if (i_q == '0) begin
                            state_d = ST_POST;
                        end else begin
                            i_d     = i_q - LEN_W'(1);
                            state_d = ST_SQ;
                        end
                    end
                end
                ST_POST: begin
                    if (mm_done) begin
                        state_d = ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (issue) begin
            mult_cnt_d = mult_cnt_d + 16'd1;
        end

        mm_start_d  = issue;
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d      = (state_d == ST_FIN);
        load_a_rn_d = (state_d == ST_INIT_A);

        // Selects track the state being entered so they are stable for its whole duration
        unique case (state_d)
            ST_PRE: begin
                a_sel_d  = A_SEL_M;
                b_sel_d  = B_SEL_R2N;
                wr_dst_d = DST_XT;
            end
            ST_SQ: begin
                a_sel_d = A_SEL_AREG;
                b_sel_d = B_SEL_AREG;
            end
            ST_MUL: begin
                a_sel_d = A_SEL_AREG;
                b_sel_d = B_SEL_XT;
            end
            ST_POST: begin
                a_sel_d = A_SEL_AREG;
                b_sel_d = B_SEL_ONE;
            end
            default: begin
                a_sel_d = A_SEL_AREG;
                b_sel_d = B_SEL_AREG;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            exp_q       <= '0;
            len_q       <= '0;
            i_q         <= '0;
            mult_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mm_start_q  <= 1'b0;
            a_sel_q     <= A_SEL_AREG;
            b_sel_q     <= B_SEL_AREG;
            wr_dst_q    <= DST_A;
            load_a_rn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            exp_q       <= exp_d;
            len_q       <= len_d;
            i_q         <= i_d;
            mult_cnt_q  <= mult_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mm_start_q  <= mm_start_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            wr_dst_q    <= wr_dst_d;
            load_a_rn_q <= load_a_rn_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mm_start  = mm_start_q;
    assign mm_a_sel  = a_sel_q;
    assign mm_b_sel  = b_sel_q;
    assign wr_dst    = wr_dst_q;
    assign load_a_rn = load_a_rn_q;
    assign mult_cnt  = mult_cnt_q;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Bench for rsa_exp_sequencer: mock Montgomery multiplier (latency 4) with A / X~
// registers, scoreboard queues of expected operation sequences and final results.
module tb_rsa_exp_sequencer;

    localparam int unsigned EXP_W = 32;
    localparam int unsigned LEN_W = 6;
    localparam int          L     = 4;
    localparam longint unsigned N_MOD = 64'd58281;
    localparam longint unsigned M_VAL = 64'd12345;

    // {a_sel, b_sel, wr_dst}
    localparam logic [4:0] OP_PRE  = 5'b01_10_1;
    localparam logic [4:0] OP_SQ   = 5'b00_00_0;
    localparam logic [4:0] OP_MUL  = 5'b00_01_0;
    localparam logic [4:0] OP_POST = 5'b00_11_0;

    typedef struct {
        longint unsigned result;
        int              k;
        int              cycles;
    } exp_t;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [EXP_W-1:0] exp_in;
    logic [LEN_W-1:0] exp_len_in;
    logic             busy;
    logic             done;
    logic             mm_start;
    logic [1:0]       mm_a_sel;
    logic [1:0]       mm_b_sel;
    logic             mm_done;
    logic             mm_busy;
    logic             wr_en;
    logic             wr_dst;
    logic             load_a_rn;
    logic [15:0]      mult_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] op_q[$];
    exp_t       res_q[$];

    longint unsigned areg, xreg, mm_res, rn, r2n, opa, opb;
    int              mm_cnt;
    int              wr_cnt = 0;
    int              sq_seen = 0;
    int              mul_seen = 0;
    logic [4:0]      op_got;
    logic [4:0]      op_exp;

    rsa_exp_sequencer #(.EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .exp       (exp_in),
        .exp_len   (exp_len_in),
        .busy      (busy),
        .done      (done),
        .mm_start  (mm_start),
        .mm_a_sel  (mm_a_sel),
        .mm_b_sel  (mm_b_sel),
        .mm_done   (mm_done),
        .mm_busy   (mm_busy),
        .wr_en     (wr_en),
        .wr_dst    (wr_dst),
        .load_a_rn (load_a_rn),
        .mult_cnt  (mult_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Bit-serial Montgomery product a*b*2^-16 mod N
    function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        t = a * b;
        for (int k = 0; k < 16; k++) begin
            if (t[0]) t = t + N_MOD;
            t = t >> 1;
        end
        if (t >= N_MOD) t = t - N_MOD;
        return t;
    endfunction

    // Plain modular exponentiation, independent of the Montgomery domain
    function automatic longint unsigned modexp(input logic [31:0] e, input int len);
        longint unsigned r;
        r = 1;
        for (int b = len - 1; b >= 0; b--) begin
            r = (r * r) % N_MOD;
            if (((e >> b) & 32'd1) != 32'd0) r = (r * M_VAL) % N_MOD;
        end
        return r;
    endfunction

    always_comb begin
        opa = (mm_a_sel == 2'd1) ? M_VAL : areg;
        case (mm_b_sel)
            2'd0:    opb = areg;
            2'd1:    opb = xreg;
            2'd2:    opb = r2n;
            default: opb = 64'd1;
        endcase
    end

    // Mock multiplier: mm_done exactly L cycles after mm_start
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm_busy <= 1'b0;
            mm_done <= 1'b0;
            mm_cnt  <= 0;
        end else begin
            mm_done <= 1'b0;
            if (mm_start && !mm_busy) begin
                mm_busy <= 1'b1;
                mm_cnt  <= L - 2;
                mm_res  <= mont(opa, opb);
            end else if (mm_busy) begin
                if (mm_cnt == 0) begin
                    mm_busy <= 1'b0;
                    mm_done <= 1'b1;
                end else begin
                    mm_cnt <= mm_cnt - 1;
                end
            end
        end
    end

    // External A / X~ registers
    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (wr_dst) xreg <= mm_res;
            else        areg <= mm_res;
        end
        if (load_a_rn) areg <= rn;
    end

    // Operation-sequence scoreboard
    always @(posedge clk) begin
        #1;
        if (resetn && mm_start) begin
            op_got = {mm_a_sel, mm_b_sel, wr_dst};
            if (op_got == OP_SQ)  sq_seen++;
            if (op_got == OP_MUL) mul_seen++;
            if (op_q.size() == 0) begin
                check_eq("op_unexpected", 64'(op_q.size()), 64'd1);
            end else begin
                op_exp = op_q.pop_front();
                check_eq("op_sel", 64'(op_got), 64'(op_exp));
            end
        end
    end

    task automatic begin_run(input logic [31:0] e, input int len_in);
        int len;
        int k;
        exp_t ex;
        len = (len_in > int'(EXP_W)) ? int'(EXP_W) : len_in;
        op_q.push_back(OP_PRE);
        k = 2;
        for (int b = len - 1; b >= 0; b--) begin
            op_q.push_back(OP_SQ);
            k++;
            if (((e >> b) & 32'd1) != 32'd0) begin
                op_q.push_back(OP_MUL);
                k++;
            end
        end
        op_q.push_back(OP_POST);
        ex.result = modexp(e, len);
        ex.k      = k;
        ex.cycles = k * (L + 1) + 2;
        res_q.push_back(ex);
        @(negedge clk);
        exp_in     = e;
        exp_len_in = LEN_W'(len_in);
        start      = 1'b1;
        @(posedge clk);
        #1;
        check_eq("launch_mm_start", 64'(mm_start), 64'd1);
        check_eq("launch_busy", 64'(busy), 64'd1);
    endtask

    task automatic finish_run(input string tag);
        exp_t ex;
        int   cyc;
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ex = res_q.pop_front();
        check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(ex.cycles));
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_mult_cnt"}, 64'(mult_cnt), 64'(ex.k));
        check_eq({tag, "_result"}, areg, ex.result);
        check_eq({tag, "_ops_left"}, 64'(op_q.size()), 64'd0);
    endtask

    task automatic drop_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_done_fall"}, 64'(done), 64'd0);
        check_eq({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_mm_start"}, 64'(mm_start), 64'd0);
        check_eq({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check_eq({tag, "_wr_dst"}, 64'(wr_dst), 64'd0);
        check_eq({tag, "_load_a_rn"}, 64'(load_a_rn), 64'd0);
        check_eq({tag, "_a_sel"}, 64'(mm_a_sel), 64'd0);
        check_eq({tag, "_b_sel"}, 64'(mm_b_sel), 64'd0);
        check_eq({tag, "_mult_cnt"}, 64'(mult_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int wr_base;
        rn         = (64'd1 << 16) % N_MOD;
        r2n        = (rn * rn) % N_MOD;
        areg       = 0;
        xreg       = 0;
        mm_res     = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        exp_in     = '0;
        exp_len_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Main run; then hold start to confirm done stays and nothing relaunches
        begin_run(32'h9985, 16);
        finish_run("run_9985");
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            check_eq("hold_done", 64'(done), 64'd1);
            check_eq("hold_no_start", 64'(mm_start), 64'd0);
        end
        drop_start("run_9985");

        begin_run(32'h1234, 0);
        finish_run("len0");
        drop_start("len0");

        begin_run(32'hFFFF_FFFF, 40);
        finish_run("clamp");
        drop_start("clamp");

        // Abort during the third squaring
        sq_seen = 0;
        begin_run(32'h9985, 16);
        cyc = 0;
        while (sq_seen < 3 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("abort_reach_sq3", 64'(sq_seen), 64'd3);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        op_q.delete();
        res_q.delete();
        wr_base = wr_cnt;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_mm_start", 64'(mm_start), 64'd0);
        @(negedge clk);
        check_eq("relaunch_gate_mm_busy", 64'(mm_busy), 64'd1);
        start = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            check_eq("relaunch_blocked", 64'(busy), 64'd0);
        end
        check_eq("abort_no_wr", 64'(wr_cnt - wr_base), 64'd0);
        check_eq("abort_mult_idle", 64'(mm_busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        begin_run(32'h9985, 16);
        finish_run("relaunch");
        drop_start("relaunch");

        // Asynchronous reset in the middle of a multiply step
        mul_seen = 0;
        begin_run(32'h9985, 16);
        cyc = 0;
        while (mul_seen < 1 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("rst_reach_mul", 64'(mul_seen), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        op_q.delete();
        res_q.delete();
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        begin_run(32'h0000_0005, 3);
        finish_run("after_rst");
        drop_start("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
